// File: rtl/onchip_ram_arbiter_if.sv
// rtl/onchip_ram_arbiter_if.sv - Avalon-MM bundle for two masters plus the shared RAM port
`timescale 1ns/1ps

interface onchip_ram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              reset_req;

    logic [ADDR_W-1:0] s0_address;
    logic [BE_W-1:0]   s0_byteenable;
    logic              s0_read;
    logic              s0_write;
    logic [DATA_W-1:0] s0_writedata;
    logic [DATA_W-1:0] s0_readdata;
    logic              s0_waitrequest;
    logic              s0_readdatavalid;

    logic [ADDR_W-1:0] s1_address;
    logic [BE_W-1:0]   s1_byteenable;
    logic              s1_read;
    logic              s1_write;
    logic [DATA_W-1:0] s1_writedata;
    logic [DATA_W-1:0] s1_readdata;
    logic              s1_waitrequest;
    logic              s1_readdatavalid;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  reset_req,
        input  s0_address, s0_byteenable, s0_read, s0_write, s0_writedata,
        output s0_readdata, s0_waitrequest, s0_readdatavalid,
        input  s1_address, s1_byteenable, s1_read, s1_write, s1_writedata,
        output s1_readdata, s1_waitrequest, s1_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
        input  ram_readdata
    );

    modport master (
        output reset_req,
        output s0_address, s0_byteenable, s0_read, s0_write, s0_writedata,
        input  s0_readdata, s0_waitrequest, s0_readdatavalid,
        output s1_address, s1_byteenable, s1_read, s1_write, s1_writedata,
        input  s1_readdata, s1_waitrequest, s1_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
        output ram_readdata
    );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// rtl/onchip_ram_arbiter.sv - round-robin, burst-bounded arbiter sharing one single-port RAM between two masters
`timescale 1ns/1ps

module onchip_ram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_ram_arbiter_if.slave   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic             owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_pend0_q, rd_pend0_d;
    logic             rd_pend1_q, rd_pend1_d;

    logic req0, req1, allow, gnt0, gnt1;

    assign req0  = bus.s0_read | bus.s0_write;
    assign req1  = bus.s1_read | bus.s1_write;
    // Reset gates grants combinationally so waitrequest is high for the whole reset pulse.
    assign allow = ~reset & ~bus.reset_req;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (allow) begin
            if (req0 && req1) begin
                if (burst_cnt_q < MAX_CNT) begin
                    gnt0 = ~owner_q;
                    gnt1 = owner_q;
                end else begin
                    gnt0 = owner_q;
                    gnt1 = ~owner_q;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (gnt0 || gnt1) begin
            // gnt1 doubles as the index of the granted port.
            if (gnt1 == owner_q) begin
                if (burst_cnt_q < MAX_CNT) begin
                    burst_cnt_d = burst_cnt_q + ONE_CNT;
                end
            end else begin
                owner_d     = gnt1;
                burst_cnt_d = ONE_CNT;
            end
        end
        rd_pend0_d = gnt0 & bus.s0_read & ~bus.s0_write;
        rd_pend1_d = gnt1 & bus.s1_read & ~bus.s1_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= 1'b0;
            burst_cnt_q <= '0;
            rd_pend0_q  <= 1'b0;
            rd_pend1_q  <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend0_q  <= rd_pend0_d;
            rd_pend1_q  <= rd_pend1_d;
        end
    end

    always_comb begin
        bus.ram_address    = '0;
        bus.ram_byteenable = '0;
        bus.ram_writedata  = '0;
        bus.ram_write      = 1'b0;
        bus.ram_chipselect = gnt0 | gnt1;
        if (gnt0) begin
            bus.ram_address    = bus.s0_address;
            bus.ram_byteenable = bus.s0_byteenable;
            bus.ram_writedata  = bus.s0_writedata;
            bus.ram_write      = bus.s0_write;
        end else if (gnt1) begin
            bus.ram_address    = bus.s1_address;
            bus.ram_byteenable = bus.s1_byteenable;
            bus.ram_writedata  = bus.s1_writedata;
            bus.ram_write      = bus.s1_write;
        end
    end

    assign bus.s0_waitrequest   = ~gnt0;
    assign bus.s1_waitrequest   = ~gnt1;
    assign bus.s0_readdatavalid = rd_pend0_q;
    assign bus.s1_readdatavalid = rd_pend1_q;
    assign bus.s0_readdata      = bus.ram_readdata;
    assign bus.s1_readdata      = bus.ram_readdata;

    logic [BE_W-1:0] unused_be;
    assign unused_be = '0;
endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb/tb_onchip_ram_arbiter.sv - scoreboard bench for onchip_ram_arbiter with a behavioural RAM
`timescale 1ns/1ps

module tb_onchip_ram_arbiter;
    localparam int DEPTH = 16384;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    onchip_ram_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    onchip_ram_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram_mem [0:DEPTH-1];
    logic [31:0] shadow  [0:DEPTH-1];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always @(posedge clk) begin
        if (bus.ram_chipselect) begin
            if (bus.ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byteenable[b]) ram_mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
            end else begin
                bus.ram_readdata <= ram_mem[bus.ram_address];
            end
        end
    end

    function automatic void shadow_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Scoreboard: pop/compare returned data, then push reads accepted this cycle.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            checks++;
            if (bus.s0_readdatavalid) begin
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL sb0_unexpected_valid: readdatavalid=1 required 0 at %0t", $time);
                end else begin
                    exp = q0.pop_front();
                    if (bus.s0_readdata !== exp) begin
                        fails++;
                        $display("FAIL sb0_data: got %h required %h at %0t", bus.s0_readdata, exp, $time);
                    end
                end
            end else if (q0.size() != 0) begin
                fails++;
                $display("FAIL sb0_missing_valid: readdatavalid=0 required 1 at %0t", $time);
                q0.delete();
            end
            checks++;
            if (bus.s1_readdatavalid) begin
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL sb1_unexpected_valid: readdatavalid=1 required 0 at %0t", $time);
                end else begin
                    exp = q1.pop_front();
                    if (bus.s1_readdata !== exp) begin
                        fails++;
                        $display("FAIL sb1_data: got %h required %h at %0t", bus.s1_readdata, exp, $time);
                    end
                end
            end else if (q1.size() != 0) begin
                fails++;
                $display("FAIL sb1_missing_valid: readdatavalid=0 required 1 at %0t", $time);
                q1.delete();
            end
            if (!bus.s0_waitrequest) begin
                if (bus.s0_write) shadow_write(bus.s0_address, bus.s0_writedata, bus.s0_byteenable);
                else if (bus.s0_read) q0.push_back(shadow[bus.s0_address]);
            end
            if (!bus.s1_waitrequest) begin
                if (bus.s1_write) shadow_write(bus.s1_address, bus.s1_writedata, bus.s1_byteenable);
                else if (bus.s1_read) q1.push_back(shadow[bus.s1_address]);
            end
        end
    end

    task automatic drive(input int p, input logic rd, input logic wr, input logic [13:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            bus.s0_read = rd; bus.s0_write = wr; bus.s0_address = a;
            bus.s0_writedata = d; bus.s0_byteenable = be;
        end else begin
            bus.s1_read = rd; bus.s1_write = wr; bus.s1_address = a;
            bus.s1_writedata = d; bus.s1_byteenable = be;
        end
    endtask

    task automatic idle_both();
        drive(0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.reset_req = 1'b0;
        drive(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 14'h11, 32'h0, 4'hF);
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (bus.s0_waitrequest !== 1'b1 || bus.s1_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL reset_waitrequest: got %b%b required 11", bus.s0_waitrequest, bus.s1_waitrequest);
        end
        checks++;
        if (bus.s0_readdatavalid !== 1'b0 || bus.s1_readdatavalid !== 1'b0 || bus.ram_chipselect !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid %b%b cs %b required 000",
                     bus.s0_readdatavalid, bus.s1_readdatavalid, bus.ram_chipselect);
        end
        next_cycle();
        idle_both();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        next_cycle();
        drive(0, 1'b0, 1'b1, 14'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.s0_waitrequest !== 1'b0 || bus.ram_write !== 1'b1 || bus.ram_address !== 14'h10) begin
            fails++;
            $display("FAIL wr_accept: wait %b ram_write %b addr %h required 0 1 0010",
                     bus.s0_waitrequest, bus.ram_write, bus.ram_address);
        end
        next_cycle();
        drive(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.s0_waitrequest !== 1'b0 || bus.s0_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL rd_accept: wait %b valid %b required 0 0", bus.s0_waitrequest, bus.s0_readdatavalid);
        end
        next_cycle();
        idle_both();
        @(negedge clk);
        checks++;
        if (bus.s0_readdatavalid !== 1'b1 || bus.s0_readdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rd_return: valid %b data %h required 1 deadbeef", bus.s0_readdatavalid, bus.s0_readdata);
        end
    endtask

    task automatic test_byte_write();
        next_cycle();
        drive(1, 1'b0, 1'b1, 14'h10, 32'h000000AA, 4'h1);
        next_cycle();
        drive(1, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        next_cycle();
        idle_both();
        @(negedge clk);
        checks++;
        if (bus.s1_readdatavalid !== 1'b1 || bus.s1_readdata !== 32'hDEADBEAA) begin
            fails++;
            $display("FAIL byte_write: valid %b data %h required 1 deadbeaa", bus.s1_readdatavalid, bus.s1_readdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(0, 1'b0, 1'b1, 14'h40 + 14'(i), 32'hA0000000 + 32'(i), 4'hF);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(0, 1'b1, 1'b0, 14'h40 + 14'(i), 32'h0, 4'hF);
            @(negedge clk);
            checks++;
            if (i > 0 && bus.s0_readdatavalid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_valid[%0d]: got %b required 1", i, bus.s0_readdatavalid);
            end
        end
        next_cycle();
        idle_both();
        next_cycle();
    endtask

    task automatic test_round_robin();
        int exp_g [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 14'h40, 32'h0, 4'hF);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s0_waitrequest !== (exp_g[i] != 0) || bus.s1_waitrequest !== (exp_g[i] == 0)) begin
                fails++;
                $display("FAIL rr_grant[%0d]: wait %b%b required grant to port %0d",
                         i, bus.s0_waitrequest, bus.s1_waitrequest, exp_g[i]);
            end
            if (i > 0) begin
                checks++;
                if (bus.s0_readdatavalid !== (exp_g[i-1] == 0) || bus.s1_readdatavalid !== (exp_g[i-1] != 0)) begin
                    fails++;
                    $display("FAIL rr_valid[%0d]: valid %b%b required port %0d",
                             i, bus.s0_readdatavalid, bus.s1_readdatavalid, exp_g[i-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_req();
        int exp_g [4] = '{1, 1, 1, 0};
        @(negedge clk);
        checks++;
        if (bus.s1_waitrequest !== 1'b0) begin
            fails++;
            $display("FAIL rq_pre_grant: s1 wait %b required 0", bus.s1_waitrequest);
        end
        next_cycle();
        bus.reset_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ram_chipselect !== 1'b0 || bus.s0_waitrequest !== 1'b1 || bus.s1_waitrequest !== 1'b1) begin
                fails++;
                $display("FAIL rq_block[%0d]: cs %b wait %b%b required 0 11",
                         i, bus.ram_chipselect, bus.s0_waitrequest, bus.s1_waitrequest);
            end
            if (i == 0) begin
                checks++;
                if (bus.s1_readdatavalid !== 1'b1 || bus.s1_readdata !== 32'hA0000000) begin
                    fails++;
                    $display("FAIL rq_inflight: valid %b data %h required 1 a0000000",
                             bus.s1_readdatavalid, bus.s1_readdata);
                end
            end
            next_cycle();
        end
        bus.reset_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s0_waitrequest !== (exp_g[i] != 0) || bus.s1_waitrequest !== (exp_g[i] == 0)) begin
                fails++;
                $display("FAIL rq_resume[%0d]: wait %b%b required grant to port %0d",
                         i, bus.s0_waitrequest, bus.s1_waitrequest, exp_g[i]);
            end
            next_cycle();
        end
        idle_both();
        next_cycle();
    endtask

    task automatic test_read_write_collision();
        drive(0, 1'b1, 1'b1, 14'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.ram_write !== 1'b1 || bus.ram_chipselect !== 1'b1 || bus.ram_address !== 14'h20) begin
            fails++;
            $display("FAIL rw_write: ram_write %b cs %b addr %h required 1 1 0020",
                     bus.ram_write, bus.ram_chipselect, bus.ram_address);
        end
        next_cycle();
        idle_both();
        @(negedge clk);
        checks++;
        if (bus.s0_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL rw_no_valid: got %b required 0", bus.s0_readdatavalid);
        end
        next_cycle();
        drive(0, 1'b1, 1'b0, 14'h20, 32'h0, 4'hF);
        next_cycle();
        idle_both();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.s1_waitrequest !== 1'b0) begin
            fails++;
            $display("FAIL mr_grant: s1 wait %b required 0", bus.s1_waitrequest);
        end
        next_cycle();
        reset = 1'b1;
        idle_both();
        @(negedge clk);
        checks++;
        if (bus.s1_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL mr_dropped: valid %b required 0", bus.s1_readdatavalid);
        end
        next_cycle();
        drive(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 14'h40, 32'h0, 4'hF);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s0_waitrequest !== 1'b0 || bus.s1_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL mr_first_tie: wait %b%b required 01", bus.s0_waitrequest, bus.s1_waitrequest);
        end
        next_cycle();
        idle_both();
        repeat (2) next_cycle();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h0;
            shadow[i]  = 32'h0;
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_round_robin();
        test_reset_req();
        test_read_write_collision();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/onchip_ram_arbiter.md
# onchip_ram_arbiter

Two-port Avalon-MM arbiter that shares one single-port on-chip RAM (16K x 32, byte-enabled, one-cycle read latency, unregistered output) between two masters, e.g. the Nios II data master and a DMA/streaming engine. Each cycle at most one request reaches the RAM. Selection is round-robin with a bounded burst per owner. Non-granted masters are stalled via `waitrequest`; read data returns through a per-port `readdatavalid` pipeline.

## Interface
- `ADDR_W`, 14, word address width (RAM depth 2^ADDR_W)
- `DATA_W`, 32, data width; byteenable width = DATA_W/8
- `MAX_BURST`, 4, max consecutive grants to the owner while the other port is requesting (>=1)

- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high reset
- `reset_req`  in  1  RAM access inhibit; no new grants while high
- `s0_address` / `s1_address`  in  ADDR_W  word address
- `s0_byteenable` / `s1_byteenable`  in  DATA_W/8  byte lanes
- `s0_read` / `s1_read`  in  1  read request
- `s0_write` / `s1_write`  in  1  write request
- `s0_writedata` / `s1_writedata`  in  DATA_W  write data
- `s0_readdata` / `s1_readdata`  out  DATA_W  read data, qualified by readdatavalid
- `s0_waitrequest` / `s1_waitrequest`  out  1  stall; request not accepted this cycle
- `s0_readdatavalid` / `s1_readdatavalid`  out  1  read data valid
- `ram_address`  out  ADDR_W  to RAM
- `ram_byteenable`  out  DATA_W/8  to RAM
- `ram_chipselect`  out  1  access issued this cycle
- `ram_write`  out  1  write strobe
- `ram_writedata`  out  DATA_W  to RAM
- `ram_readdata`  in  DATA_W  RAM q, valid 1 cycle after a read is issued

## Operation
- `req_i = s_i_read | s_i_write`. If read and write are both high, write wins; the read is ignored (no readdatavalid).
- Registered state: `owner` (0/1), `burst_cnt` (0..MAX_BURST, saturating), `rd_pend0`, `rd_pend1`.
- Grant (combinational, at most one):
  - `reset_req`=1 or no req: no grant.
  - Only one port requesting: that port.
  - Both requesting: `owner` if `burst_cnt < MAX_BURST`, else the other port.
- State update on grant g: if g==owner then `burst_cnt <= min(burst_cnt+1, MAX_BURST)`, else `owner <= g`, `burst_cnt <= 1`. No grant: state holds.
- RAM drive: `ram_chipselect = grant any`; `ram_write = grant & write of granted port`; address/byteenable/writedata muxed from the granted port; all zero when there is no grant.
- `s_i_waitrequest = ~grant_i` (high when idle, not granted, or `reset_req`).
- `rd_pend_i <= grant_i & s_i_read & ~s_i_write`; `s_i_readdatavalid = rd_pend_i`; `s_i_readdata = ram_readdata` (broadcast to both ports, qualified by valid).
- A read issued in cycle N completes in N+1 even if `reset_req` rises in N+1.

## Timing
- Reset values: `owner`=0, `burst_cnt`=0, `rd_pend*`=0. While `reset` is high, both readdatavalid outputs are 0 and both waitrequest outputs are 1 (grants forced off).
- Accept latency: 0 cycles. A request is accepted in the cycle waitrequest is low.
- Read latency: exactly 1 cycle from acceptance to readdatavalid. Back-to-back reads give one valid per cycle.
- Throughput: one access per cycle total. With both ports saturating, the pattern is MAX_BURST grants to one port, then MAX_BURST to the other.
- Reset asserted mid-read: the pending valid is dropped. After deassertion, the first tie goes to port 0.
- Masters hold address/data/strobes stable while waitrequest is high (Avalon rule; not checked).

## Test plan
- Port 0 writes 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then reads addr 0x0010 -> waitrequest low on both transactions; s0_readdatavalid high exactly 1 cycle after the read, with s0_readdata=0xDEADBEEF.
- Byte write: port 1 writes 0x000000AA to addr 0x0010 with byteenable 0x1, then reads -> readdata 0xDEADBEAA.
- After reset, both ports read continuously for 12 cycles with MAX_BURST=4 -> grant order 0,0,0,0,1,1,1,1,0,0,0,0; the non-granted waitrequest is high in every cycle; each port's readdatavalid mirrors its own grants delayed 1 cycle.
- `reset_req` held high for 3 cycles with both ports requesting -> ram_chipselect=0 and both waitrequest=1; a read granted the cycle before `reset_req` rose still returns readdatavalid; arbitration state is unchanged afterwards.
- Port 0 asserts read and write together at addr 0x20 -> RAM sees a write; no s0_readdatavalid.
- `reset` asserted in the cycle after a read grant -> readdatavalid stays 0; after release, a simultaneous request from both ports grants port 0.
